// File: rtl/fetch_stage.sv
// fetch_stage: issues in-order instruction fetches for the current PC,
// tracks in-flight requests with credits, buffers returned instructions
// with their PCs and hands them to decode over a valid/ready handshake.
// Ports:
//   clk_i, rst_i (sync, active-high), flush_i, pc_i, fetch_ready_o
//   mem_req_valid_o/ready_i/addr_o, mem_rsp_valid_i/ready_o/instr_i/except_i
//   instr_valid_o/ready_i, instr_o, instr_pc_o, instr_except_o
module fetch_stage #(
    parameter int XLEN            = 64,
    parameter int ILEN            = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int BUF_DEPTH       = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            fetch_ready_o,
    output logic            mem_req_valid_o,
    input  logic            mem_req_ready_i,
    output logic [XLEN-1:0] mem_req_addr_o,
    input  logic            mem_rsp_valid_i,
    output logic            mem_rsp_ready_o,
    input  logic [ILEN-1:0] mem_rsp_instr_i,
    input  logic            mem_rsp_except_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [ILEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            instr_except_o
);

    // One shared counter width holds inflight + buffer occupancy.
    localparam int CW = $clog2(BUF_DEPTH + MAX_OUTSTANDING + 1);
    localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int BW = $clog2(BUF_DEPTH);

    localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
    localparam logic [CW-1:0] ONE     = CW'(1);

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            except;
    } entry_t;

    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   buf_cnt;

    logic [XLEN-1:0] pcq [MAX_OUTSTANDING];
    logic [QW-1:0]   pcq_wr;
    logic [QW-1:0]   pcq_rd;

    entry_t          buf_mem [BUF_DEPTH];
    logic [BW-1:0]   buf_wr;
    logic [BW-1:0]   buf_rd;

    logic            req_fire;
    logic            rsp_take;
    logic            rsp_keep;
    logic            deq;
    logic [CW-1:0]   inc;
    logic [CW-1:0]   dec;

    function automatic logic [QW-1:0] q_next(input logic [QW-1:0] p);
        return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + QW'(1);
    endfunction

    function automatic logic [BW-1:0] b_next(input logic [BW-1:0] p);
        return (p == BW'(BUF_DEPTH - 1)) ? '0 : p + BW'(1);
    endfunction

    // Credits: never issue more than the buffer could absorb, counting
    // every in-flight request as an already-occupied slot.
    assign mem_req_valid_o = !rst_i && !flush_i
                           && (inflight < MAX_C)
                           && ((inflight + buf_cnt) < DEPTH_C);
    assign mem_req_addr_o  = pc_i;
    assign fetch_ready_o   = mem_req_valid_o && mem_req_ready_i;
    assign mem_rsp_ready_o = !rst_i;

    assign req_fire = fetch_ready_o;
    // A stray response with nothing in flight is ignored to keep the
    // counters from underflowing.
    assign rsp_take = mem_rsp_valid_i && (inflight != '0);
    assign rsp_keep = rsp_take && (drop_cnt == '0) && !flush_i;

    assign instr_valid_o  = (buf_cnt != '0);
    assign deq            = instr_valid_o && instr_ready_i && !flush_i;
    assign instr_o        = buf_mem[buf_rd].instr;
    assign instr_pc_o     = buf_mem[buf_rd].pc;
    assign instr_except_o = buf_mem[buf_rd].except;

    assign inc = rsp_keep ? ONE : '0;
    assign dec = deq ? ONE : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight <= '0;
            drop_cnt <= '0;
            buf_cnt  <= '0;
            pcq_wr   <= '0;
            pcq_rd   <= '0;
            buf_wr   <= '0;
            buf_rd   <= '0;
        end else begin
            inflight <= inflight
                      + (req_fire ? ONE : '0)
                      - (rsp_take ? ONE : '0);
            if (flush_i) begin
                // Everything still outstanding after this cycle is stale.
                drop_cnt <= inflight - (rsp_take ? ONE : '0);
                pcq_wr   <= '0;
                pcq_rd   <= '0;
                buf_wr   <= '0;
                buf_rd   <= '0;
                buf_cnt  <= '0;
            end else begin
                if (rsp_take && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - ONE;
                end
                if (req_fire) begin
                    pcq[pcq_wr] <= pc_i;
                    pcq_wr      <= q_next(pcq_wr);
                end
                if (rsp_keep) begin
                    buf_mem[buf_wr] <= '{instr:  mem_rsp_instr_i,
                                         pc:     pcq[pcq_rd],
                                         except: mem_rsp_except_i};
                    buf_wr <= b_next(buf_wr);
                    pcq_rd <= q_next(pcq_rd);
                end
                if (deq) begin
                    buf_rd <= b_next(buf_rd);
                end
                buf_cnt <= buf_cnt + inc - dec;
            end
        end
    end

endmodule
